// File: rtl/instr_fetch.sv
// Instruction fetch stage for the RV32I core.
// Holds the program counter, fetches one word at a time over a req/ack
// handshake, and hands the word plus its address to decode with valid/ready.
// Branch redirects come back from decode in the same cycle decode accepts.
module instr_fetch #(
  parameter int                   D_WIDTH  = 32,
  parameter logic [D_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [D_WIDTH-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [D_WIDTH-1:0] imem_rdata,
  output logic [D_WIDTH-1:0] instr,
  output logic [D_WIDTH-1:0] instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               PCsrc,
  input  logic [D_WIDTH-1:0] ImmOp,
  output logic               fetch_err
);

  typedef enum logic {
    FETCH = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [D_WIDTH-1:0] r_pc;
  logic [D_WIDTH-1:0] r_instr;
  logic [D_WIDTH-1:0] r_instr_pc;
  logic               r_instr_valid;
  logic               r_fetch_err;

  logic               w_req;
  logic               w_capture;
  logic               w_accept;
  logic [D_WIDTH-1:0] w_seq_pc;
  logic [D_WIDTH-1:0] w_target;
  logic [D_WIDTH-1:0] w_redirect_pc;
  logic               w_misaligned;

  // State register: reset lands in FETCH so fetching starts as soon as rst drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: one request outstanding at a time, and nothing is
  // prefetched while an instruction waits for decode, so a redirect never
  // has an in-flight fetch to squash.
  always_comb begin
    w_next_state = r_state;
    w_req        = 1'b0;
    w_capture    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      FETCH: begin
        w_req = 1'b1;
        if (imem_ack) begin
          w_capture    = 1'b1;
          w_next_state = VALID;
        end
      end
      VALID: begin
        if (instr_ready) begin
          w_accept     = 1'b1;
          w_next_state = FETCH;
        end
      end
      default: begin
        w_next_state = FETCH;
      end
    endcase
  end

  // Next-PC arithmetic: sequential step or branch target relative to the
  // accepted instruction, both wrapping modulo 2^D_WIDTH. The target's low
  // bits are dropped so memory always sees a word-aligned address; a nonzero
  // remainder is reported through fetch_err instead.
  always_comb begin
    w_seq_pc      = r_instr_pc + D_WIDTH'(4);
    w_target      = r_instr_pc + ImmOp;
    w_redirect_pc = {w_target[D_WIDTH-1:2], 2'b00};
    w_misaligned  = |w_target[1:0];
  end

  // Datapath registers: capture the fetched word on ack, advance the PC on
  // accept. instr/instr_pc are left untouched on accept since decode ignores
  // them once instr_valid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
    end else begin
      r_fetch_err <= 1'b0;
      if (w_capture) begin
        r_instr       <= imem_rdata;
        r_instr_pc    <= r_pc;
        r_instr_valid <= 1'b1;
      end
      if (w_accept) begin
        r_instr_valid <= 1'b0;
        if (PCsrc) begin
          r_pc        <= w_redirect_pc;
          r_fetch_err <= w_misaligned;
        end else begin
          r_pc <= w_seq_pc;
        end
      end
    end
  end

  // Output drive: the request is masked by rst so memory sees nothing while
  // the core is held in reset, even though the state is already FETCH.
  always_comb begin
    imem_req    = w_req & ~rst;
    imem_addr   = r_pc;
    instr       = r_instr;
    instr_pc    = r_instr_pc;
    instr_valid = r_instr_valid;
    fetch_err   = r_fetch_err;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a per-cycle vector table drives the
// memory and decode sides and lists the outputs expected before each edge.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        PCsrc;
  logic [31:0] ImmOp;
  logic        fetch_err;

  int nChecks = 0;
  int nFails  = 0;
  int rowIdx  = 0;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        pcsrc;
    logic [31:0] imm;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eValid;
    logic [31:0] eInstr;
    logic [31:0] ePc;
    logic        eErr;
    logic        chkInstr;
  } vec_t;

  vec_t vecs[$];

  instr_fetch #(
    .D_WIDTH  (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .PCsrc       (PCsrc),
    .ImmOp       (ImmOp),
    .fetch_err   (fetch_err)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic r, input logic a, input logic [31:0] d,
                              input logic rdy, input logic ps, input logic [31:0] im,
                              input logic eq, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ei, input logic [31:0] ep,
                              input logic ee, input logic ci);
    vec_t v;
    v.rst = r; v.ack = a; v.rdata = d; v.ready = rdy; v.pcsrc = ps; v.imm = im;
    v.eReq = eq; v.eAddr = ea; v.eValid = ev; v.eInstr = ei; v.ePc = ep;
    v.eErr = ee; v.chkInstr = ci;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst         = v.rst;
    imem_ack    = v.ack;
    imem_rdata  = v.rdata;
    instr_ready = v.ready;
    PCsrc       = v.pcsrc;
    ImmOp       = v.imm;
  endtask

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL row %0d %s: got %h expected %h", rowIdx, name, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v);
    checkField("imem_req", {31'b0, imem_req}, {31'b0, v.eReq});
    if (v.eReq) checkField("imem_addr", imem_addr, v.eAddr);
    checkField("instr_valid", {31'b0, instr_valid}, {31'b0, v.eValid});
    checkField("fetch_err", {31'b0, fetch_err}, {31'b0, v.eErr});
    if (v.chkInstr) begin
      checkField("instr", instr, v.eInstr);
      checkField("instr_pc", instr_pc, v.ePc);
    end
  endtask

  // Inputs change 2 units after a rising edge; outputs are sampled at the
  // falling edge, i.e. the values that the next rising edge will act upon.
  task automatic runVec(input vec_t v);
    @(posedge clk);
    #2;
    applyStimulus(v);
    @(negedge clk);
    checkOutput(v);
    rowIdx++;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    PCsrc = 1'b0; ImmOp = '0;

    //          rst ack rdata         rdy ps imm            req addr          vld instr         pc            err chk
    // Zero-wait memory, decode always ready
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        0, 1));
    vecs.push_back(mk(0, 1, 32'h00500093, 1, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h00500093, 32'h0,        0, 1));
    vecs.push_back(mk(0, 1, 32'h00108113, 1, 0, 32'h0,        1, 32'h4,        0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h00108113, 32'h4,        0, 1));
    // Reset while waiting at pc=8, then a 3-cycle delayed ack
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 1, 32'h00000013, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0,        0, 0));
    // Decode stalls 5 cycles; a spurious ack must be ignored
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h100,      0, 32'h0,        1, 32'h00000013, 32'h0,        0, 1));
    vecs.push_back(mk(0, 1, 32'hFFFFFFFF, 0, 1, 32'h100,      0, 32'h0,        1, 32'h00000013, 32'h0,        0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h00000013, 32'h0,        0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h00000013, 32'h0,        0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h00000013, 32'h0,        0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h00000013, 32'h0,        0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h4,        0, 32'h0,        32'h0,        0, 0));
    // Forward branch 4 -> 0x10, backward 0x10 -> 0x08, back to 0x10, then fall-through to 0x14
    vecs.push_back(mk(0, 1, 32'h00c0006f, 0, 0, 32'h0,        1, 32'h4,        0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0000000C, 0, 32'h0,        1, 32'h00c0006f, 32'h4,        0, 1));
    vecs.push_back(mk(0, 1, 32'hA0A0A0A0, 0, 0, 32'h0,        1, 32'h10,       0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'hFFFFFFF8, 0, 32'h0,        1, 32'hA0A0A0A0, 32'h10,       0, 1));
    vecs.push_back(mk(0, 1, 32'hB0B0B0B0, 0, 0, 32'h0,        1, 32'h08,       0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h00000008, 0, 32'h0,        1, 32'hB0B0B0B0, 32'h08,       0, 1));
    vecs.push_back(mk(0, 1, 32'hC0C0C0C0, 0, 0, 32'h0,        1, 32'h10,       0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'hFFFFFFF8, 0, 32'h0,        1, 32'hC0C0C0C0, 32'h10,       0, 1));
    vecs.push_back(mk(0, 1, 32'hD0D0D0D0, 0, 0, 32'h0,        1, 32'h14,       0, 32'h0,        32'h0,        0, 0));
    // Branch 0x14 -> 0x20, then misaligned target 0x26 -> 0x24 with fetch_err
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0000000C, 0, 32'h0,        1, 32'hD0D0D0D0, 32'h14,       0, 1));
    vecs.push_back(mk(0, 1, 32'hE0E0E0E0, 0, 0, 32'h0,        1, 32'h20,       0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h00000006, 0, 32'h0,        1, 32'hE0E0E0E0, 32'h20,       0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h24,       0, 32'h0,        32'h0,        1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h24,       0, 32'h0,        32'h0,        0, 0));
    // Walk to pc=0x40 and wait there
    vecs.push_back(mk(0, 1, 32'h01C0006F, 0, 0, 32'h0,        1, 32'h24,       0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0000001C, 0, 32'h0,        1, 32'h01C0006F, 32'h24,       0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h40,       0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h40,       0, 32'h0,        32'h0,        0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      runVec(vecs[i]);
    end

    // Reset asserted between edges while waiting at 0x40: request drops at
    // once, and fetching resumes at RESET_PC once rst is released.
    runVec(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        0, 1));
    runVec(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0,        0, 0));
    runVec(mk(0, 1, 32'h12345678, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0,        0, 0));
    runVec(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h12345678, 32'h0,        0, 1));
    // Reset while an instruction is buffered: it must be discarded immediately.
    runVec(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        0, 1));
    runVec(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0,        0, 0));
    // Backward branch from 0 to 0xFFFFFFFC, then sequential step wraps to 0.
    runVec(mk(0, 1, 32'hFFDFF06F, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0,        0, 0));
    runVec(mk(0, 0, 32'h0,        1, 1, 32'hFFFFFFFC, 0, 32'h0,        1, 32'hFFDFF06F, 32'h0,        0, 1));
    runVec(mk(0, 1, 32'h00000073, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h0,        32'h0,        0, 0));
    runVec(mk(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h00000073, 32'hFFFFFFFC, 0, 1));
    runVec(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0,        0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage of the RV32I core, directly upstream of the decode/sign-extend logic.
- Holds the program counter and fetches one instruction word at a time from instruction memory over a req/ack handshake.
- Presents the instruction and its PC to decode with a valid/ready handshake.
- Consumes ImmOp and PCsrc from decode to compute the next PC. A taken branch redirects to instr_pc + ImmOp.

Parameters:
- D_WIDTH, 32, instruction and address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  D_WIDTH  word-aligned fetch address; valid while imem_req=1.
- imem_ack  in  1  memory response strobe; imem_rdata is valid in the same cycle.
- imem_rdata  in  D_WIDTH  fetched instruction word.
- instr  out  D_WIDTH  instruction presented to decode.
- instr_pc  out  D_WIDTH  address of instr.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  decode accepts instr this cycle.
- PCsrc  in  1  branch taken for the instruction being accepted; sampled only on accept.
- ImmOp  in  D_WIDTH  sign-extended branch offset for the instruction being accepted.
- fetch_err  out  1  one-cycle pulse: redirect target was misaligned.

Behaviour:
- Reset (async, immediate on rst=1):
  - state=FETCH, pc=RESET_PC.
  - instr=0, instr_pc=0, instr_valid=0, fetch_err=0.
  - imem_req stays 0 while rst=1 and rises in the first cycle after rst deasserts.
- State FETCH:
  - imem_req=1, imem_addr=pc; imem_addr is held stable until ack.
  - Memory may ack in the same cycle as req (zero wait) or any number of cycles later.
  - On imem_ack=1: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, state<=VALID.
- State VALID:
  - imem_req=0; any imem_ack is ignored.
  - instr, instr_pc and instr_valid hold stable while instr_ready=0, for an unbounded stall.
- Accept (instr_valid=1 and instr_ready=1 in VALID):
  - PCsrc=0: pc<=instr_pc+4.
  - PCsrc=1: target=instr_pc+ImmOp; pc<={target[D_WIDTH-1:2],2'b00}.
  - fetch_err pulses for one cycle if target[1:0]!=0.
  - Next state FETCH; instr_valid<=0.
  - instr and instr_pc keep their old values, which are don't-care.
- Throughput and latency:
  - Minimum 2 cycles per instruction with a zero-wait memory.
  - Ack-to-instr_valid latency is 1 cycle.
  - Accept-to-next-imem_req is 1 cycle.
- Arithmetic:
  - All additions are modulo 2^D_WIDTH.
  - pc wraps from 32'hFFFF_FFFC to 0 with no flag.
  - Negative ImmOp (two's complement) gives backward branches.
- PCsrc and ImmOp are don't-care outside the accept cycle.
- fetch_err is asserted only in the cycle after a misaligned-target accept; otherwise 0.
- Reset mid-operation:
  - An outstanding request is abandoned; instruction memory is reset by the same rst.
  - A buffered instruction is discarded (instr_valid=0).
  - Fetch restarts at RESET_PC.
- There is only ever one outstanding memory request, and no speculative prefetch, so a redirect never needs a squash.

Test Plan:
- Reset then zero-wait memory returning 32'h00500093 at 0 and 32'h00108113 at 4, instr_ready=1:
  - imem_addr 0 then 4; instr_valid high every second cycle.
  - instr_pc 0 then 4; instr matches the memory words.
- Memory ack delayed 3 cycles:
  - imem_req and imem_addr=0 held for all 4 cycles.
  - instr_valid rises exactly 1 cycle after ack.
- instr_ready held low 5 cycles while instr_valid=1, with a spurious imem_ack pulse:
  - instr and instr_pc unchanged.
  - imem_req stays 0; no extra fetch.
- Accept at instr_pc=32'h10 with PCsrc=1, ImmOp=32'hFFFF_FFF8:
  - next imem_addr=32'h08.
  - with PCsrc=0 instead, next imem_addr=32'h14.
- Accept at instr_pc=32'h20 with PCsrc=1, ImmOp=32'h6:
  - fetch_err pulses 1 cycle.
  - next imem_addr=32'h24 (low bits cleared).
- rst asserted mid-wait at pc=32'h40:
  - outputs cleared immediately.
  - after release, imem_addr=RESET_PC.
- Accept at pc=32'hFFFF_FFFC with PCsrc=0: next imem_addr=0 (wrap).
